// File: rtl/output_sr_pkg.sv
// output_sr_pkg
// Shared constants and helpers for the output shift buffer.
//   DWIDTH_DEF / LANES_DEF / DEPTH_DEF : default geometry (16-bit words, 2 lanes, 8 entries)
//   PTR_W_DEF / CNT_W_DEF              : pointer and occupancy widths for the defaults
//   ptr_width()                        : pointer width for an arbitrary depth (min 1 bit)
//   write_fits()                       : all-or-nothing write acceptance test
package output_sr_pkg;

    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned LANES_DEF  = 2;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF + 1);

    // A depth of 1 still needs a one-bit pointer so the array index is legal.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy used here is the value at the start of the cycle, so a
    // same-cycle pop never creates room for the write.
    function automatic logic write_fits(input int unsigned count_pre,
                                        input int unsigned n,
                                        input int unsigned lanes,
                                        input int unsigned depth);
        return (n <= lanes) && ((count_pre + n) <= depth);
    endfunction

endpackage

// File: rtl/output_sr_mem.sv
// output_sr_mem
// DEPTH x DWIDTH storage with LANES independent write ports and one
// registered read port. Stored words are never reset; only the read
// register is.
//   clk, reset : clock, asynchronous active-high reset (read register only)
//   wr_en      : per-lane write enable
//   wr_addr    : per-lane write address, lane k at [k*PTR_W +: PTR_W]
//   wr_data    : per-lane write data, lane k at [k*DWIDTH +: DWIDTH]
//   rd_en      : load rd_data from rd_addr on the next rising edge
//   rd_addr    : read address
//   rd_data    : registered read data, holds when rd_en is low
module output_sr_mem
    import output_sr_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned PTR_W  = PTR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0]          wr_en,
    input  logic [LANES*PTR_W-1:0]    wr_addr,
    input  logic [LANES*DWIDTH-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [PTR_W-1:0]          rd_addr,
    output logic [DWIDTH-1:0]         rd_data
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;

    // Lane addresses are always distinct when enabled together, so the
    // order of the loop never matters.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_addr[k*PTR_W +: PTR_W]] <= wr_data[k*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/output_sr_param.sv
// output_sr_param
// Output shift buffer for the CGRA tile output path: accepts up to LANES
// words per cycle (lane 0 first), stores them in a DEPTH-entry circular
// buffer and drains one word per read request in arrival order.
//   clk, reset : clock, asynchronous active-high reset
//   data_in    : packed write words, lane k at [k*DWIDTH +: DWIDTH]
//   wr_cnt     : number of lanes to push (0 = none); >LANES is rejected
//   ren        : pop request
//   data_out   : registered popped word, holds when no pop is accepted
//   valid      : data_out was loaded by a pop on the previous cycle
//   avail      : buffer non-empty
//   full       : a max-size write can no longer be guaranteed
//   count      : current occupancy
// Optional feature macro OUTPUT_SR_OVF_EN adds:
//   ovf        : sticky flag, set the cycle after a rejected non-zero write
//   ovf_clr    : clears ovf (wins over a same-cycle set)
module output_sr_param
    import output_sr_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LANES*DWIDTH-1:0]       data_in,
    input  logic [$clog2(LANES+1)-1:0]    wr_cnt,
    input  logic                          ren,
    output logic [DWIDTH-1:0]             data_out,
    output logic                          valid,
    output logic                          avail,
    output logic                          full,
    output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef OUTPUT_SR_OVF_EN
    ,
    output logic                          ovf,
    input  logic                          ovf_clr
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wp_q, wp_d;
    logic [PTR_W-1:0]       rp_q, rp_d;
    logic                   valid_q;
    logic                   wr_accept;
    logic                   rd_accept;
    int unsigned            cnt_u;
    int unsigned            wc_u;
    logic [LANES-1:0]       lane_wr_en;
    logic [LANES*PTR_W-1:0] lane_wr_addr;

    always_comb begin
        cnt_u     = 32'(count_q);
        wc_u      = 32'(wr_cnt);
        wr_accept = write_fits(cnt_u, wc_u, LANES, DEPTH);
        rd_accept = ren && (count_q != '0);
        count_d   = CNT_W'(cnt_u - (rd_accept ? 32'd1 : 32'd0) + (wr_accept ? wc_u : 32'd0));
        wp_d      = wr_accept ? PTR_W'((32'(wp_q) + wc_u) % DEPTH) : wp_q;
        rp_d      = rd_accept ? PTR_W'((32'(rp_q) + 32'd1) % DEPTH) : rp_q;
    end

    // Lane k lands at (wp + k) mod DEPTH, so a burst straddling the end of
    // the array keeps its order.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_wr_en[gi] = wr_accept && (32'(gi) < wc_u);
        assign lane_wr_addr[gi*PTR_W +: PTR_W] = PTR_W'((32'(wp_q) + 32'(gi)) % DEPTH);
    end

    output_sr_mem #(
        .DWIDTH (DWIDTH),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (lane_wr_en),
        .wr_addr (lane_wr_addr),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rp_q),
        .rd_data (data_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            valid_q <= rd_accept;
        end
    end

`ifdef OUTPUT_SR_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end else if ((wc_u != 0) && !wr_accept) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    assign valid = valid_q;
    assign count = count_q;
    assign avail = (count_q != '0);
    assign full  = ((32'(count_q) + LANES) > DEPTH);

endmodule

// File: tb/tb_output_sr_param.sv
module tb_output_sr_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [1:0]  wr_cnt;
    logic        ren;
    logic [15:0] data_out;
    logic        valid;
    logic        avail;
    logic        full;
    logic [3:0]  count;
`ifdef OUTPUT_SR_OVF_EN
    logic        ovf;
    logic        ovf_clr;
`endif

    int checks = 0;
    int errors = 0;

    output_sr_param #(.DWIDTH(16), .LANES(2), .DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .wr_cnt   (wr_cnt),
        .ren      (ren),
        .data_out (data_out),
        .valid    (valid),
        .avail    (avail),
        .full     (full),
        .count    (count)
`ifdef OUTPUT_SR_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] n, input logic [15:0] l0, input logic [15:0] l1);
        wr_cnt  = n;
        data_in = {l1, l0};
    endtask

    initial begin
        reset   = 1'b1;
        data_in = '0;
        wr_cnt  = '0;
        ren     = 1'b0;
`ifdef OUTPUT_SR_OVF_EN
        ovf_clr = 1'b0;
`endif
        #1;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_avail", 32'(avail), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
`ifdef OUTPUT_SR_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'h0);
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic two-lane burst, lane 0 first out.
        wr(2, 16'hAAAA, 16'hBBBB);
        tick();
        chk("burst_count", 32'(count), 32'd2);
        chk("burst_avail", 32'(avail), 32'd1);
        chk("burst_valid", 32'(valid), 32'd0);
        wr(0, 16'h0, 16'h0);
        ren = 1'b1;
        tick();
        chk("pop1_data", 32'(data_out), 32'hAAAA);
        chk("pop1_valid", 32'(valid), 32'd1);
        chk("pop1_count", 32'(count), 32'd1);
        tick();
        chk("pop2_data", 32'(data_out), 32'hBBBB);
        chk("pop2_valid", 32'(valid), 32'd1);
        chk("pop2_avail", 32'(avail), 32'd0);

        // Read on empty: ignored, data holds.
        tick();
        chk("empty_valid", 32'(valid), 32'd0);
        chk("empty_data", 32'(data_out), 32'hBBBB);

        // Write + read on empty: no bypass.
        wr(1, 16'h1111, 16'h0);
        tick();
        chk("nobyp_valid", 32'(valid), 32'd0);
        chk("nobyp_data", 32'(data_out), 32'hBBBB);
        chk("nobyp_count", 32'(count), 32'd1);
        wr(0, 16'h0, 16'h0);
        tick();
        chk("nobyp_pop", 32'(data_out), 32'h1111);
        chk("nobyp_pvalid", 32'(valid), 32'd1);
        chk("nobyp_pcount", 32'(count), 32'd0);
        ren = 1'b0;

        // Fill to DEPTH (wp starts at 3 here, so the fill wraps).
        wr(2, 16'h0101, 16'h0102);
        tick();
        wr(2, 16'h0103, 16'h0104);
        tick();
        wr(2, 16'h0105, 16'h0106);
        tick();
        chk("fill6_count", 32'(count), 32'd6);
        chk("fill6_full", 32'(full), 32'd0);
        wr(2, 16'h0107, 16'h0108);
        tick();
        chk("fill8_count", 32'(count), 32'd8);
        chk("fill8_full", 32'(full), 32'd1);
        wr(1, 16'hDEAD, 16'h0);
        tick();
        chk("ovfw_count", 32'(count), 32'd8);
`ifdef OUTPUT_SR_OVF_EN
        chk("ovf_set", 32'(ovf), 32'd1);
        wr(0, 16'h0, 16'h0);
        tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
`endif
        wr(0, 16'h0, 16'h0);
        ren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_data", 32'(data_out), 32'h0101 + 32'(i));
        end
        ren = 1'b0;
        chk("drain_count", 32'(count), 32'd0);

        // Advance pointers to 7, then write a burst straddling 7 -> 0.
        wr(2, 16'h0003, 16'h0004);
        tick();
        wr(2, 16'h0005, 16'h0006);
        tick();
        wr(0, 16'h0, 16'h0);
        ren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("adv_data", 32'(data_out), 32'h0003 + 32'(i));
        end
        ren = 1'b0;
        wr(2, 16'h0007, 16'h0008);
        tick();
        chk("wrap_count", 32'(count), 32'd2);
        wr(0, 16'h0, 16'h0);
        ren = 1'b1;
        tick();
        chk("wrap_data7", 32'(data_out), 32'h0007);
        tick();
        chk("wrap_data8", 32'(data_out), 32'h0008);
        ren = 1'b0;

        // Oversize request is always rejected.
        wr(3, 16'h0001, 16'h0002);
        tick();
        chk("big_count", 32'(count), 32'd0);
`ifdef OUTPUT_SR_OVF_EN
        chk("big_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("clr_wins", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
`endif

        // Count 7, simultaneous read and 2-word write: write rejected.
        wr(2, 16'h0A01, 16'h0A02);
        tick();
        wr(2, 16'h0A03, 16'h0A04);
        tick();
        wr(2, 16'h0A05, 16'h0A06);
        tick();
        wr(1, 16'h0A07, 16'h0);
        tick();
        chk("c7_count", 32'(count), 32'd7);
        chk("c7_full", 32'(full), 32'd1);
        wr(2, 16'hEEEE, 16'hEEEE);
        ren = 1'b1;
        tick();
        chk("c7_rw_count", 32'(count), 32'd6);
        chk("c7_rw_data", 32'(data_out), 32'h0A01);
        chk("c7_rw_valid", 32'(valid), 32'd1);
        wr(0, 16'h0, 16'h0);
        tick();
        chk("c5_data", 32'(data_out), 32'h0A02);
        chk("c5_count", 32'(count), 32'd5);
        ren = 1'b0;

        // Asynchronous reset mid-stream.
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_data", 32'(data_out), 32'h0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_avail", 32'(avail), 32'd0);
        chk("mrst_full", 32'(full), 32'd0);
        tick();
        reset = 1'b0;
        wr(1, 16'h5555, 16'h0);
        tick();
        chk("post_count", 32'(count), 32'd1);
        wr(0, 16'h0, 16'h0);
        ren = 1'b1;
        tick();
        chk("post_data", 32'(data_out), 32'h5555);
        chk("post_valid", 32'(valid), 32'd1);
        ren = 1'b0;
        tick();
        chk("post_hold", 32'(data_out), 32'h5555);
        chk("post_vlow", 32'(valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
